cv32e40p_ex_issue_ctrl: RTL and testbench

EX-stage consumer of the ID/EX pipeline register. It tracks the instruction resident in EX and waits for the multiplier, ALU and LSU to finish. It returns `ex_ready_o` and `mult_multicycle_o` to ID/EX, and hands ALU-port results to WB through a one-deep registered writeback buffer with a valid/ready handshake. A saturating stall counter supports the fault-tolerant monitoring effort.

---
 rtl/cv32e40p_ex_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cv32e40p_ex_issue_ctrl.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_ex_issue_ctrl.sv
// EX-stage issue controller: tracks the instruction resident in EX, waits on
// the multiplier, ALU and LSU, and hands ALU-port results to WB through a
// one-deep registered writeback buffer. Also keeps a saturating count of
// cycles in which the resident instruction could not complete.
module cv32e40p_ex_issue_ctrl #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,

  input  logic                 id_valid_i,

  input  logic                 alu_en_ex_i,
  input  logic                 mult_en_ex_i,
  input  logic                 data_req_ex_i,
  input  logic                 csr_access_ex_i,

  input  logic                 regfile_alu_we_ex_i,
  input  logic [5:0]           regfile_alu_waddr_ex_i,

  input  logic [31:0]          alu_result_i,
  input  logic [31:0]          mult_result_i,
  input  logic [31:0]          csr_rdata_i,

  input  logic                 alu_ready_i,
  input  logic                 mult_ready_i,
  input  logic                 lsu_ready_ex_i,

  input  logic                 wb_ready_i,
  input  logic                 clear_cnt_i,

  output logic                 ex_ready_o,
  output logic                 ex_valid_o,
  output logic                 mult_multicycle_o,

  output logic                 wb_valid_o,
  output logic                 wb_we_o,
  output logic [5:0]           wb_waddr_o,
  output logic [31:0]          wb_wdata_o,

  output logic [2:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  typedef enum logic [2:0] {
    EMPTY     = 3'd0,
    EXEC      = 3'd1,
    MULT_WAIT = 3'd2,
    LSU_WAIT  = 3'd3,
    WB_WAIT   = 3'd4
  } state_e;

  state_e               state_q;
  state_e               state_d;

  logic                 wb_valid_q;
  logic [5:0]           wb_waddr_q;
  logic [31:0]          wb_wdata_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  logic                 active;
  logic                 mult_blocked;
  logic                 lsu_blocked;
  logic                 units_done;
  logic                 wb_slot;
  logic                 complete;
  logic                 wb_load;
  logic                 cnt_sat;
  logic [31:0]          result_sel;

  // The ALU enable does not gate completion: alu_ready_i is expected to be
  // high whenever the ALU is idle, so it is accepted but not consumed.
  logic                 unused_alu_en;
  assign unused_alu_en = alu_en_ex_i;

  assign active       = (state_q != EMPTY);
  assign mult_blocked = mult_en_ex_i & ~mult_ready_i;
  assign lsu_blocked  = data_req_ex_i & ~lsu_ready_ex_i;
  assign units_done   = ~mult_blocked & alu_ready_i & ~lsu_blocked;

  // A writing instruction needs either an empty buffer or one being drained
  // at this very edge; non-writing instructions ignore the buffer.
  assign wb_slot  = ~wb_valid_q | wb_ready_i;
  assign complete = active & units_done & (~regfile_alu_we_ex_i | wb_slot);

  assign wb_load  = complete & regfile_alu_we_ex_i;
  assign cnt_sat  = &stall_cnt_q;

  // Multiplier result outranks a CSR read, which outranks the plain ALU result.
  assign result_sel = mult_en_ex_i    ? mult_result_i :
                      csr_access_ex_i ? csr_rdata_i   :
                                        alu_result_i;

  // Next-state selection: completion first, otherwise report the first blocker.
  always_comb begin
    state_d = state_q;
    if (!active) begin
      if (id_valid_i) begin
        state_d = EXEC;
      end
    end else if (complete) begin
      state_d = id_valid_i ? EXEC : EMPTY;
    end else if (mult_blocked) begin
      state_d = MULT_WAIT;
    end else if (lsu_blocked) begin
      state_d = LSU_WAIT;
    end else if (!alu_ready_i) begin
      state_d = EXEC;
    end else begin
      state_d = WB_WAIT;
    end
  end

  // State register; a low clk_en freezes the FSM where it is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Writeback buffer: a new load beats a simultaneous drain so throughput stays 1/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
    end else if (clk_en) begin
      if (wb_load) begin
        wb_valid_q <= 1'b1;
        wb_waddr_q <= regfile_alu_waddr_ex_i;
        wb_wdata_q <= result_sel;
      end else if (wb_ready_i) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  // Stall counter: clear wins, otherwise count blocked cycles and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (clk_en) begin
      if (clear_cnt_i) begin
        stall_cnt_q <= '0;
      end else if (active && !complete && !cnt_sat) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign ex_ready_o        = clk_en & (~active | complete);
  assign ex_valid_o        = clk_en & complete;
  assign mult_multicycle_o = active & mult_blocked;

  assign wb_valid_o  = clk_en & wb_valid_q;
  assign wb_we_o     = wb_valid_o;
  assign wb_waddr_o  = wb_waddr_q;
  assign wb_wdata_o  = wb_wdata_q;

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_cv32e40p_ex_issue_ctrl.sv
// Testbench for cv32e40p_ex_issue_ctrl: vector table of single-cycle issues,
// hand-written multi-cycle sequences, and a writeback scoreboard.
module tb_cv32e40p_ex_issue_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic          id_valid_i;
  logic          alu_en_ex_i;
  logic          mult_en_ex_i;
  logic          data_req_ex_i;
  logic          csr_access_ex_i;
  logic          regfile_alu_we_ex_i;
  logic [5:0]    regfile_alu_waddr_ex_i;
  logic [31:0]   alu_result_i;
  logic [31:0]   mult_result_i;
  logic [31:0]   csr_rdata_i;
  logic          alu_ready_i;
  logic          mult_ready_i;
  logic          lsu_ready_ex_i;
  logic          wb_ready_i;
  logic          clear_cnt_i;
  logic          ex_ready_o;
  logic          ex_valid_o;
  logic          mult_multicycle_o;
  logic          wb_valid_o;
  logic          wb_we_o;
  logic [5:0]    wb_waddr_o;
  logic [31:0]   wb_wdata_o;
  logic [2:0]    state_o;
  logic [CW-1:0] stall_cnt_o;

  int tests;
  int fails;

  typedef struct {
    logic        we;
    logic        mult_en;
    logic        csr;
    logic        data_req;
    logic [5:0]  waddr;
    logic [31:0] alu;
    logic [31:0] mul;
    logic [31:0] csrd;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [5:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  vec_t vecs[6];
  wb_t  sb_q[$];

  cv32e40p_ex_issue_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .clk_en                 (clk_en),
    .id_valid_i             (id_valid_i),
    .alu_en_ex_i            (alu_en_ex_i),
    .mult_en_ex_i           (mult_en_ex_i),
    .data_req_ex_i          (data_req_ex_i),
    .csr_access_ex_i        (csr_access_ex_i),
    .regfile_alu_we_ex_i    (regfile_alu_we_ex_i),
    .regfile_alu_waddr_ex_i (regfile_alu_waddr_ex_i),
    .alu_result_i           (alu_result_i),
    .mult_result_i          (mult_result_i),
    .csr_rdata_i            (csr_rdata_i),
    .alu_ready_i            (alu_ready_i),
    .mult_ready_i           (mult_ready_i),
    .lsu_ready_ex_i         (lsu_ready_ex_i),
    .wb_ready_i             (wb_ready_i),
    .clear_cnt_i            (clear_cnt_i),
    .ex_ready_o             (ex_ready_o),
    .ex_valid_o             (ex_valid_o),
    .mult_multicycle_o      (mult_multicycle_o),
    .wb_valid_o             (wb_valid_o),
    .wb_we_o                (wb_we_o),
    .wb_waddr_o             (wb_waddr_o),
    .wb_wdata_o             (wb_wdata_o),
    .state_o                (state_o),
    .stall_cnt_o            (stall_cnt_o)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setIdle();
    id_valid_i             = 1'b0;
    alu_en_ex_i            = 1'b0;
    mult_en_ex_i           = 1'b0;
    data_req_ex_i          = 1'b0;
    csr_access_ex_i        = 1'b0;
    regfile_alu_we_ex_i    = 1'b0;
    regfile_alu_waddr_ex_i = 6'd0;
    alu_result_i           = 32'h0;
    mult_result_i          = 32'h0;
    csr_rdata_i            = 32'h0;
    alu_ready_i            = 1'b1;
    mult_ready_i           = 1'b1;
    lsu_ready_ex_i         = 1'b1;
    clear_cnt_i            = 1'b0;
  endtask

  task automatic pushWb(input logic [5:0] a, input logic [31:0] d);
    wb_t e;
    e.waddr = a;
    e.wdata = d;
    sb_q.push_back(e);
  endtask

  // Drives the EX-stage fields of one resident instruction from a table row.
  task automatic applyStimulus(input vec_t v);
    alu_en_ex_i            = 1'b1;
    mult_en_ex_i           = v.mult_en;
    csr_access_ex_i        = v.csr;
    data_req_ex_i          = v.data_req;
    regfile_alu_we_ex_i    = v.we;
    regfile_alu_waddr_ex_i = v.waddr;
    alu_result_i           = v.alu;
    mult_result_i          = v.mul;
    csr_rdata_i            = v.csrd;
    alu_ready_i            = 1'b1;
    mult_ready_i           = 1'b1;
    lsu_ready_ex_i         = 1'b1;
    if (v.we) pushWb(v.waddr, v.exp_wdata);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_state"},     32'(state_o),           32'd0);
    checkOutput({tag, "_wb_valid"},  32'(wb_valid_o),        32'd0);
    checkOutput({tag, "_wb_we"},     32'(wb_we_o),           32'd0);
    checkOutput({tag, "_wb_waddr"},  32'(wb_waddr_o),        32'd0);
    checkOutput({tag, "_wb_wdata"},  wb_wdata_o,             32'd0);
    checkOutput({tag, "_stall_cnt"}, 32'(stall_cnt_o),       32'd0);
    checkOutput({tag, "_ex_ready"},  32'(ex_ready_o),        32'd1);
    checkOutput({tag, "_ex_valid"},  32'(ex_valid_o),        32'd0);
    checkOutput({tag, "_mult_mc"},   32'(mult_multicycle_o), 32'd0);
  endtask

  // Scoreboard: every accepted writeback must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_valid_o && wb_ready_i) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL sb_unexpected: got waddr 0x%0h wdata 0x%0h, expected no writeback", wb_waddr_o, wb_wdata_o);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        checkOutput("sb_waddr", 32'(wb_waddr_o), 32'(e.waddr));
        checkOutput("sb_wdata", wb_wdata_o, e.wdata);
        checkOutput("sb_we",    32'(wb_we_o),    32'd1);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tests = 0;
    fails = 0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd1,  32'h0000_0011, 32'h0,         32'h0,         32'h0000_0011};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd2,  32'h0000_0022, 32'h0,         32'hC5C5_C5C5, 32'hC5C5_C5C5};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd3,  32'h0000_0055, 32'h0000_3333, 32'h0000_0044, 32'h0000_3333};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd63, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd9,  32'h0000_0099, 32'h0,         32'h0,         32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd32, 32'h0000_0001, 32'h8000_0000, 32'h0,         32'h8000_0000};

    setIdle();
    clk_en     = 1'b1;
    wb_ready_i = 1'b1;
    rst_n      = 1'b0;
    tick();
    tick();
    settle();
    checkReset("rst");
    tick();
    rst_n = 1'b1;

    // Single-cycle ALU write to x5.
    id_valid_i = 1'b1;
    settle();
    checkOutput("alu_empty_ready", 32'(ex_ready_o), 32'd1);
    tick();
    setIdle();
    alu_en_ex_i = 1'b1; regfile_alu_we_ex_i = 1'b1;
    regfile_alu_waddr_ex_i = 6'd5; alu_result_i = 32'h1234;
    pushWb(6'd5, 32'h1234);
    settle();
    checkOutput("alu_c1_valid", 32'(ex_valid_o), 32'd1);
    checkOutput("alu_c1_ready", 32'(ex_ready_o), 32'd1);
    checkOutput("alu_c1_state", 32'(state_o),    32'd1);
    tick();
    setIdle();
    settle();
    checkOutput("alu_c2_wbvalid", 32'(wb_valid_o),  32'd1);
    checkOutput("alu_c2_waddr",   32'(wb_waddr_o),  32'd5);
    checkOutput("alu_c2_wdata",   wb_wdata_o,       32'h1234);
    checkOutput("alu_c2_state",   32'(state_o),     32'd0);
    checkOutput("alu_c2_stall",   32'(stall_cnt_o), 32'd0);
    tick();
    settle();
    checkOutput("alu_c3_wbvalid", 32'(wb_valid_o), 32'd0);

    // Multiply that waits three cycles on mult_ready.
    id_valid_i = 1'b1;
    tick();
    setIdle();
    alu_en_ex_i = 1'b1; mult_en_ex_i = 1'b1; mult_ready_i = 1'b0;
    regfile_alu_we_ex_i = 1'b1; regfile_alu_waddr_ex_i = 6'd7;
    mult_result_i = 32'hCAFE_0001; alu_result_i = 32'h11;
    pushWb(6'd7, 32'hCAFE_0001);
    for (int c = 0; c < 3; c++) begin
      if (c != 0) tick();
      settle();
      checkOutput("mul_state",   32'(state_o),           (c == 0) ? 32'd1 : 32'd2);
      checkOutput("mul_mc",      32'(mult_multicycle_o), 32'd1);
      checkOutput("mul_ready",   32'(ex_ready_o),        32'd0);
      checkOutput("mul_valid",   32'(ex_valid_o),        32'd0);
    end
    tick();
    mult_ready_i = 1'b1;
    settle();
    checkOutput("mul_done_state", 32'(state_o),           32'd2);
    checkOutput("mul_done_valid", 32'(ex_valid_o),        32'd1);
    checkOutput("mul_done_mc",    32'(mult_multicycle_o), 32'd0);
    checkOutput("mul_done_stall", 32'(stall_cnt_o),       32'd3);
    tick();
    setIdle();
    settle();
    checkOutput("mul_wb_valid", 32'(wb_valid_o), 32'd1);
    checkOutput("mul_wb_wdata", wb_wdata_o,      32'hCAFE_0001);
    checkOutput("mul_wb_state", 32'(state_o),    32'd0);

    // Non-writing load waiting two cycles on the LSU.
    id_valid_i = 1'b1;
    tick();
    setIdle();
    alu_en_ex_i = 1'b1; data_req_ex_i = 1'b1; lsu_ready_ex_i = 1'b0;
    alu_result_i = 32'h0000_0400;
    settle();
    checkOutput("ld_c1_state",   32'(state_o),    32'd1);
    checkOutput("ld_c1_ready",   32'(ex_ready_o), 32'd0);
    checkOutput("ld_c1_wbvalid", 32'(wb_valid_o), 32'd0);
    tick();
    settle();
    checkOutput("ld_c2_state",   32'(state_o),    32'd3);
    checkOutput("ld_c2_wbvalid", 32'(wb_valid_o), 32'd0);
    tick();
    lsu_ready_ex_i = 1'b1;
    settle();
    checkOutput("ld_c3_state",   32'(state_o),    32'd3);
    checkOutput("ld_c3_valid",   32'(ex_valid_o), 32'd1);
    tick();
    setIdle();
    settle();
    checkOutput("ld_c4_state",   32'(state_o),     32'd0);
    checkOutput("ld_c4_wbvalid", 32'(wb_valid_o),  32'd0);
    checkOutput("ld_c4_stall",   32'(stall_cnt_o), 32'd5);

    // Full buffer with WB stalled blocks a writer, then drain and refill share an edge.
    wb_ready_i = 1'b0;
    id_valid_i = 1'b1;
    tick();
    setIdle();
    id_valid_i = 1'b1;
    alu_en_ex_i = 1'b1; regfile_alu_we_ex_i = 1'b1;
    regfile_alu_waddr_ex_i = 6'd9; alu_result_i = 32'hAAAA;
    pushWb(6'd9, 32'hAAAA);
    settle();
    checkOutput("wbw_a_valid", 32'(ex_valid_o), 32'd1);
    tick();
    setIdle();
    alu_en_ex_i = 1'b1; regfile_alu_we_ex_i = 1'b1;
    regfile_alu_waddr_ex_i = 6'd10; alu_result_i = 32'hBBBB;
    pushWb(6'd10, 32'hBBBB);
    settle();
    checkOutput("wbw_b_state", 32'(state_o),    32'd1);
    checkOutput("wbw_b_ready", 32'(ex_ready_o), 32'd0);
    checkOutput("wbw_b_waddr", 32'(wb_waddr_o), 32'd9);
    tick();
    settle();
    checkOutput("wbw_wait_state", 32'(state_o),    32'd4);
    checkOutput("wbw_wait_ready", 32'(ex_ready_o), 32'd0);
    checkOutput("wbw_wait_data",  wb_wdata_o,      32'hAAAA);
    wb_ready_i = 1'b1;
    settle();
    checkOutput("wbw_rel_ready", 32'(ex_ready_o), 32'd1);
    checkOutput("wbw_rel_valid", 32'(ex_valid_o), 32'd1);
    tick();
    setIdle();
    wb_ready_i = 1'b0;
    id_valid_i = 1'b1;
    settle();
    checkOutput("wbw_refill_valid", 32'(wb_valid_o), 32'd1);
    checkOutput("wbw_refill_data",  wb_wdata_o,      32'hBBBB);
    checkOutput("wbw_refill_waddr", 32'(wb_waddr_o), 32'd10);
    checkOutput("wbw_refill_state", 32'(state_o),    32'd0);
    tick();
    setIdle();
    alu_en_ex_i = 1'b1; data_req_ex_i = 1'b1;
    settle();
    checkOutput("wbw_store_valid", 32'(ex_valid_o), 32'd1);
    checkOutput("wbw_store_state", 32'(state_o),    32'd1);
    tick();
    setIdle();
    wb_ready_i = 1'b1;
    settle();
    checkOutput("wbw_store_done", 32'(state_o),    32'd0);
    checkOutput("wbw_still_full", 32'(wb_valid_o), 32'd1);
    checkOutput("wbw_still_data", wb_wdata_o,      32'hBBBB);
    tick();
    settle();
    checkOutput("wbw_drained", 32'(wb_valid_o), 32'd0);

    // Table-driven back-to-back issues with WB always ready.
    id_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      setIdle();
      applyStimulus(vecs[i]);
      id_valid_i = (i != 5);
      settle();
      checkOutput("vec_valid", 32'(ex_valid_o),        32'd1);
      checkOutput("vec_ready", 32'(ex_ready_o),        32'd1);
      checkOutput("vec_state", 32'(state_o),           32'd1);
      checkOutput("vec_mc",    32'(mult_multicycle_o), 32'd0);
      if (i > 0) begin
        checkOutput("vec_wbvalid", 32'(wb_valid_o), 32'(vecs[i-1].we));
        if (vecs[i-1].we) checkOutput("vec_wdata", wb_wdata_o, vecs[i-1].exp_wdata);
      end
    end
    tick();
    setIdle();
    settle();
    checkOutput("vec_end_state",   32'(state_o),    32'd0);
    checkOutput("vec_end_wbvalid", 32'(wb_valid_o), 32'd1);
    checkOutput("vec_end_wdata",   wb_wdata_o,      32'h8000_0000);
    tick();

    // Reset in the middle of MULT_WAIT with a result still buffered.
    wb_ready_i = 1'b0;
    id_valid_i = 1'b1;
    tick();
    setIdle();
    id_valid_i = 1'b1;
    alu_en_ex_i = 1'b1; regfile_alu_we_ex_i = 1'b1;
    regfile_alu_waddr_ex_i = 6'd3; alu_result_i = 32'h3333;
    tick();
    setIdle();
    alu_en_ex_i = 1'b1; mult_en_ex_i = 1'b1; mult_ready_i = 1'b0;
    regfile_alu_we_ex_i = 1'b1; regfile_alu_waddr_ex_i = 6'd4;
    mult_result_i = 32'h4444;
    tick();
    settle();
    checkOutput("rmid_state",   32'(state_o),    32'd2);
    checkOutput("rmid_wbvalid", 32'(wb_valid_o), 32'd1);
    rst_n = 1'b0;
    sb_q.delete();
    settle();
    checkReset("rmid");
    tick();
    setIdle();
    wb_ready_i = 1'b1;
    rst_n = 1'b1;
    tick();
    settle();
    checkOutput("rmid_after_wbvalid", 32'(wb_valid_o), 32'd0);

    // Counter saturation, clear, and clk_en freeze during a stall.
    id_valid_i = 1'b1;
    tick();
    setIdle();
    alu_en_ex_i = 1'b1; mult_en_ex_i = 1'b1; mult_ready_i = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    settle();
    checkOutput("sat_value", 32'(stall_cnt_o), 32'd15);
    checkOutput("sat_state", 32'(state_o),     32'd2);
    clear_cnt_i = 1'b1;
    tick();
    clear_cnt_i = 1'b0;
    settle();
    checkOutput("clr_value", 32'(stall_cnt_o), 32'd0);
    tick();
    clk_en = 1'b0;
    settle();
    checkOutput("ce0_cnt",   32'(stall_cnt_o), 32'd1);
    checkOutput("ce0_ready", 32'(ex_ready_o),  32'd0);
    tick();
    mult_ready_i = 1'b1;
    settle();
    checkOutput("ce0_hold_cnt",   32'(stall_cnt_o), 32'd1);
    checkOutput("ce0_hold_state", 32'(state_o),     32'd2);
    checkOutput("ce0_valid",      32'(ex_valid_o),  32'd0);
    checkOutput("ce0_ready2",     32'(ex_ready_o),  32'd0);
    tick();
    clk_en = 1'b1;
    settle();
    checkOutput("ce1_valid", 32'(ex_valid_o), 32'd1);
    checkOutput("ce1_ready", 32'(ex_ready_o), 32'd1);
    tick();
    setIdle();
    settle();
    checkOutput("ce1_state", 32'(state_o),     32'd0);
    checkOutput("ce1_cnt",   32'(stall_cnt_o), 32'd1);
    tick();

    checkOutput("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
